// File: rtl/sprite_render_pipeline_if.sv
// Sprite render pipeline bus.
// Groups everything except clock and reset: per-frame control (frame_start,
// char_id_req), the per-pixel request (coordinates, facing, box flag,
// qualifier, background colour), the external texel ROM port, the palette
// write port and the rendered pixel output.
//   master : the pixel source / system side (drives requests, palette writes
//            and ROM read data; observes rgb, rgb_valid, active_id, rom_addr)
//   slave  : the sprite_render_pipeline itself
interface sprite_render_pipeline_if #(
  parameter int PIXEL_WIDTH    = 12,
  parameter int SCREEN_WIDTH   = 10,
  parameter int FRAME_BITS     = 3,
  parameter int COLOR_WIDTH    = 4,
  parameter int ROM_ADDR_WIDTH = 13
);
  logic                      frame_start;
  logic [FRAME_BITS-1:0]     char_id_req;
  logic signed [1:0]         char_face;
  logic [SCREEN_WIDTH-1:0]   char_x_rom;
  logic [SCREEN_WIDTH-1:0]   char_y_rom;
  logic                      char_on;
  logic                      pix_valid;
  logic [PIXEL_WIDTH-1:0]    background_rgb;

  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [COLOR_WIDTH-1:0]    rom_data;

  logic                      pal_we;
  logic [COLOR_WIDTH-1:0]    pal_addr;
  logic [PIXEL_WIDTH-1:0]    pal_data;

  logic [PIXEL_WIDTH-1:0]    rgb;
  logic                      rgb_valid;
  logic [FRAME_BITS-1:0]     active_id;

  modport master (
    output frame_start, char_id_req, char_face, char_x_rom, char_y_rom,
           char_on, pix_valid, background_rgb, rom_data,
           pal_we, pal_addr, pal_data,
    input  rom_addr, rgb, rgb_valid, active_id
  );

  modport slave (
    input  frame_start, char_id_req, char_face, char_x_rom, char_y_rom,
           char_on, pix_valid, background_rgb, rom_data,
           pal_we, pal_addr, pal_data,
    output rom_addr, rgb, rgb_valid, active_id
  );
endinterface

// File: rtl/sprite_render_pipeline.sv
// Sprite render pipeline.
// Maps a sprite-local pixel coordinate to a texel ROM address (with optional
// horizontal mirroring and integer down-scaling), looks the returned palette
// index up in a 16-entry writable palette and composites it over the
// supplied background colour. The animation frame id is debounced across
// frame_start pulses so the sprite never changes frame mid-frame.
// Ports:
//   sys_clk  : clock
//   sys_rst  : synchronous active-high reset
//   bus      : sprite_render_pipeline_if.slave (see interface header)
// Timing: a pixel sampled at edge t produces rom_addr at edge t+1 and
// rgb/rgb_valid at edge t+ROM_LATENCY+2.
module sprite_render_pipeline #(
  parameter int                 PIXEL_WIDTH    = 12,
  parameter int                 SCREEN_WIDTH   = 10,
  parameter int                 SPRITE_W       = 42,
  parameter int                 SPRITE_H       = 50,
  parameter int                 SCALE_SHIFT    = 1,
  parameter int                 FRAME_NUM      = 8,
  parameter int                 COLOR_WIDTH    = 4,
  parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_ID = 4'hB,
  parameter int                 ROM_LATENCY    = 1,
  parameter int                 STABLE_FRAMES  = 2,
  parameter int                 ROM_ADDR_WIDTH = 13
) (
  input logic                    sys_clk,
  input logic                    sys_rst,
  sprite_render_pipeline_if.slave bus
);

  localparam int FRAME_BITS = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
  localparam int SRC_W      = SPRITE_W >> SCALE_SHIFT;
  localparam int SRC_H      = SPRITE_H >> SCALE_SHIFT;
  localparam int CNT_BITS   = $clog2(STABLE_FRAMES + 1);
  localparam int PAL_DEPTH  = 1 << COLOR_WIDTH;
  // Sideband stage 0 is loaded at the sampling edge; the last stage lines up
  // with the cycle in which rom_data is valid.
  localparam int LAST       = ROM_LATENCY + 1;

  typedef struct packed {
    logic                   valid;
    logic                   on;
    logic [PIXEL_WIDTH-1:0] bg;
  } side_t;

  // ---------------------------------------------------------------------
  // Frame id debounce
  // ---------------------------------------------------------------------
  logic [FRAME_BITS-1:0] candidate;
  logic [FRAME_BITS-1:0] cand_next;
  logic [CNT_BITS-1:0]   cnt;
  logic [CNT_BITS-1:0]   cnt_next;
  logic                  id_ok;

  // Out-of-range ids can only occur when FRAME_NUM is not a power of two.
  if (FRAME_NUM == (1 << FRAME_BITS)) begin : g_id_pow2
    assign id_ok = 1'b1;
  end else begin : g_id_range
    assign id_ok = (32'(bus.char_id_req) < 32'(FRAME_NUM));
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cand_next = candidate;
    cnt_next  = cnt;
    if (bus.char_id_req == candidate) begin
      cnt_next = (cnt == CNT_BITS'(STABLE_FRAMES)) ? cnt : cnt + 1'b1;
    end else begin
      cand_next = bus.char_id_req;
      cnt_next  = CNT_BITS'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      candidate     <= '0;
      cnt           <= '0;
      bus.active_id <= '0;
    end else if (bus.frame_start && id_ok) begin
      candidate <= cand_next;
      cnt       <= cnt_next;
      if (cnt_next == CNT_BITS'(STABLE_FRAMES)) begin
        bus.active_id <= cand_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 0: coordinate transform; stage 1: ROM address
  // ---------------------------------------------------------------------
  logic                    mirrored;
  logic [31:0]             x_src;
  logic [SCREEN_WIDTH-1:0] xs_next;
  logic [SCREEN_WIDTH-1:0] ys_next;
  logic                    pix_on;
  logic [SCREEN_WIDTH-1:0] xs_q;
  logic [SCREEN_WIDTH-1:0] ys_q;
  logic [31:0]             addr_full;
  side_t                   side_q [LAST+1];

  always_comb begin
    // Only face == -1 draws the sprite unmirrored.
    mirrored = (bus.char_face != 2'b11);
    // Off-sprite x may wrap here; such pixels are forced to background.
    x_src    = mirrored ? 32'(SPRITE_W - 1) - 32'(bus.char_x_rom)
                        : 32'(bus.char_x_rom);
    xs_next  = SCREEN_WIDTH'(x_src >> SCALE_SHIFT);
    ys_next  = bus.char_y_rom >> SCALE_SHIFT;
    pix_on   = bus.char_on
               && (32'(bus.char_x_rom) < 32'(SPRITE_W))
               && (32'(bus.char_y_rom) < 32'(SPRITE_H));
  end

  always_comb begin
    addr_full = 32'(bus.active_id) * 32'(SRC_W * SRC_H)
              + 32'(ys_q) * 32'(SRC_W)
              + 32'(xs_q);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      xs_q         <= '0;
      ys_q         <= '0;
      bus.rom_addr <= '0;
      for (int i = 0; i <= LAST; i++) begin
        side_q[i] <= '0;
      end
    end else begin
      xs_q         <= xs_next;
      ys_q         <= ys_next;
      bus.rom_addr <= ROM_ADDR_WIDTH'(addr_full);
      side_q[0]    <= '{valid: bus.pix_valid, on: pix_on, bg: bus.background_rgb};
      for (int i = 1; i <= LAST; i++) begin
        side_q[i] <= side_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Palette
  // ---------------------------------------------------------------------
  logic [PIXEL_WIDTH-1:0] palette [PAL_DEPTH];

  function automatic logic [11:0] pal_reset_val(input int idx);
    case (idx)
      0:       return 12'hACF;
      1:       return 12'h7AF;
      2:       return 12'h000;
      3:       return 12'h00F;
      4:       return 12'h008;
      5:       return 12'hF90;
      6:       return 12'hA50;
      7:       return 12'h420;
      8:       return 12'h0CF;
      9:       return 12'h13A;
      10:      return 12'h027;
      11:      return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  // NOTE: the palette is a small register file with defined power-up
  // colours, so unlike a RAM it is explicitly reset, entry by entry.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        palette[i] <= PIXEL_WIDTH'(pal_reset_val(i));
      end
    end else if (bus.pal_we) begin
      palette[bus.pal_addr] <= bus.pal_data;
    end
  end

  // ---------------------------------------------------------------------
  // Output composite. The palette is read from its registered contents, so
  // a write landing on the same edge is seen only by later pixels.
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.rgb       <= PIXEL_WIDTH'(12'hFFF);
      bus.rgb_valid <= 1'b0;
    end else begin
      bus.rgb_valid <= side_q[LAST].valid;
      if (side_q[LAST].valid) begin
        if (!side_q[LAST].on || (bus.rom_data == TRANSPARENT_ID)) begin
          bus.rgb <= side_q[LAST].bg;
        end else begin
          bus.rgb <= palette[bus.rom_data];
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_render_pipeline.sv
// Directed bench for sprite_render_pipeline with a texel ROM model
// (latency 1) and an output scoreboard of expected colour and arrival cycle.
module tb_sprite_render_pipeline;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  sprite_render_pipeline_if #(
    .PIXEL_WIDTH(12), .SCREEN_WIDTH(10), .FRAME_BITS(3),
    .COLOR_WIDTH(4), .ROM_ADDR_WIDTH(13)
  ) bus ();

  sprite_render_pipeline dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  // Texel ROM, one cycle read latency.
  logic [3:0] rom_mem [8192];
  always @(posedge sys_clk) bus.rom_data <= rom_mem[bus.rom_addr];

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  typedef struct {
    logic [11:0] rgb;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drive one pixel for one cycle and queue its expected output, which
  // arrives three edges after the sampling edge.
  task automatic pixel(input int x, input int y, input int face, input logic on,
                       input logic [11:0] bg, input logic [11:0] exp);
    bus.char_x_rom     = 10'(x);
    bus.char_y_rom     = 10'(y);
    bus.char_face      = 2'(face);
    bus.char_on        = on;
    bus.background_rgb = bg;
    bus.pix_valid      = 1'b1;
    sb.push_back('{rgb: exp, cyc: cyc + 4});
    @(negedge sys_clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic frame(input int id);
    bus.char_id_req = 3'(id);
    bus.frame_start = 1'b1;
    @(negedge sys_clk);
    bus.frame_start = 1'b0;
  endtask

  // Output monitor: sampled 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #2;
      if (bus.rgb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_rgb_valid", 32'(bus.rgb_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rgb", 32'(bus.rgb), 32'(e.rgb));
          check("latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) rom_mem[i] = 4'h0;
    rom_mem[0]    = 4'h3;  // x=0,y=0 id0
    rom_mem[2]    = 4'hB;  // transparent texel
    rom_mem[21]   = 4'h3;  // would be hit by x=42 if not forced off
    rom_mem[41]   = 4'h5;  // xs=20, ys=1
    rom_mem[45]   = 4'h0;  // xs=3, ys=2
    rom_mem[524]  = 4'h1;  // last in-box texel of frame 0
    rom_mem[525]  = 4'h3;  // would be hit by y=50 if not forced off
    rom_mem[2668] = 4'h9;  // frame 5, xs=1, ys=2

    bus.frame_start    = 1'b0;
    bus.char_id_req    = '0;
    bus.char_face      = 2'b11;
    bus.char_x_rom     = '0;
    bus.char_y_rom     = '0;
    bus.char_on        = 1'b0;
    bus.pix_valid      = 1'b0;
    bus.background_rgb = '0;
    bus.pal_we         = 1'b0;
    bus.pal_addr       = '0;
    bus.pal_data       = '0;

    // Reset state
    tick(3);
    check("rst_rgb", 32'(bus.rgb), 32'hFFF);
    check("rst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
    check("rst_active_id", 32'(bus.active_id), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    sys_rst = 1'b0;
    tick(2);

    // Latency: texel 3 at address 0 -> 00F
    pixel(0, 0, -1, 1'b1, 12'h000, 12'h00F);
    tick(1);
    check("lat_rom_addr", 32'(bus.rom_addr), 32'd0);
    tick(4);

    // Mirror / scale
    pixel(0, 2, 1, 1'b1, 12'h000, 12'hF90);
    check("mirror_addr_early", 32'(bus.rom_addr), 32'd0);
    tick(1);
    check("mirror_addr", 32'(bus.rom_addr), 32'd41);
    pixel(41, 2, -1, 1'b1, 12'h000, 12'hF90);
    tick(1);
    check("unmirror_addr", 32'(bus.rom_addr), 32'd41);
    pixel(40, 0, -2, 1'b1, 12'h000, 12'h00F);
    tick(1);
    check("mirror_face_m2_addr", 32'(bus.rom_addr), 32'd0);
    tick(4);

    // Transparency, off pixels and box boundaries, back to back
    pixel(4, 0, -1, 1'b1, 12'h0F0, 12'h0F0);
    pixel(0, 0, -1, 1'b0, 12'h123, 12'h123);
    pixel(42, 0, -1, 1'b1, 12'h456, 12'h456);
    pixel(0, 50, -1, 1'b1, 12'h789, 12'h789);
    pixel(41, 49, -1, 1'b1, 12'h0F0, 12'h7AF);
    pixel(6, 4, -1, 1'b1, 12'h0F0, 12'hACF);
    tick(5);

    // Palette write racing a lookup of the same index
    pixel(0, 0, -1, 1'b1, 12'h000, 12'h00F);
    pixel(0, 0, -1, 1'b1, 12'h000, 12'hF00);
    tick(1);
    bus.pal_we   = 1'b1;
    bus.pal_addr = 4'h3;
    bus.pal_data = 12'hF00;
    tick(1);
    bus.pal_we = 1'b0;
    tick(5);

    // Debounce
    frame(0);
    check("db_first_0", 32'(bus.active_id), 32'd0);
    bus.char_id_req = 3'd5;
    tick(2);
    check("db_no_pulse", 32'(bus.active_id), 32'd0);
    frame(5);
    check("db_5_once", 32'(bus.active_id), 32'd0);
    frame(5);
    check("db_5_twice", 32'(bus.active_id), 32'd5);
    frame(5);
    check("db_5_saturate", 32'(bus.active_id), 32'd5);

    // Pixel in frame 5
    pixel(2, 4, -1, 1'b1, 12'h000, 12'h13A);
    tick(1);
    check("id5_rom_addr", 32'(bus.rom_addr), 32'd2668);
    tick(5);
    check("hold_rgb", 32'(bus.rgb), 32'h13A);
    check("hold_rgb_valid", 32'(bus.rgb_valid), 32'd0);

    frame(6);
    check("db_toggle_6", 32'(bus.active_id), 32'd5);
    frame(5);
    check("db_toggle_5", 32'(bus.active_id), 32'd5);
    frame(6);
    check("db_toggle_6b", 32'(bus.active_id), 32'd5);
    frame(6);
    check("db_6_commit", 32'(bus.active_id), 32'd6);

    // Reset mid-stream: in-flight pixels are dropped
    pixel(0, 0, -1, 1'b1, 12'h000, 12'h000);
    pixel(0, 0, -1, 1'b1, 12'h000, 12'h000);
    sys_rst = 1'b1;
    sb.delete();
    tick(1);
    check("midrst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
    check("midrst_rgb", 32'(bus.rgb), 32'hFFF);
    check("midrst_active_id", 32'(bus.active_id), 32'd0);
    check("midrst_rom_addr", 32'(bus.rom_addr), 32'd0);
    sys_rst = 1'b0;
    tick(4);
    check("post_rst_idle_valid", 32'(bus.rgb_valid), 32'd0);

    // Palette restored: texel 3 is 00F again
    pixel(0, 0, -1, 1'b1, 12'h000, 12'h00F);
    tick(6);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
